// File: rtl/serial_subtractor.sv
// Bit-serial a - b via a + ~b + 1, LSB first, one full-adder slice per clock.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output and flop.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             borrow_q, borrow_d;
  logic             s;
  logic             c_out;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  assign s     = a_q[0] ^ b_q[0] ^ c_q;
  assign c_out = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    r_d      = r_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = ~b;
          c_d     = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d   = c_out;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {s, r_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Final bit: publish result; carry-in here is the MSB carry-in.
          diff_d   = r_d;
          borrow_d = ~c_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d    = c_q ^ c_out;
`endif
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      c_q      <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      c_q      <= c_d;
      borrow_q <= borrow_d;
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: random and directed operands
// against an arithmetic reference model, plus handshake and reset checks.
module tb_serial_subtractor;

  localparam int W = 16;
  localparam int P = W + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  exp_t exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a_i),
    .b        (b_i),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow (overflow),
`endif
    .borrow   (borrow)
  );

`ifndef SERIAL_SUB_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   sx, sy, sd;
    e.d  = W'(x - y);
    e.br = (x < y);
    sx   = int'($signed(x));
    sy   = int'($signed(y));
    sd   = sx - sy;
    e.ov = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      chk(exp_q.size() != 0, "done_unexpected", 32'(done), 32'd0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk(diff == e.d, "diff", 32'(diff), 32'(e.d));
        chk(borrow == e.br, "borrow", 32'(borrow), 32'(e.br));
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk(overflow == e.ov, "overflow", 32'(overflow), 32'(e.ov));
`endif
      end
    end
  end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    a_i   = W'($urandom);
    b_i   = W'($urandom);
    for (int i = 0; i < W; i++) begin
      if (i > 0) @(negedge clk);
      chk(busy && !done, "busy_run", {30'd0, busy, done}, 32'd2);
    end
    @(negedge clk);
    chk(!busy && done, "done_pulse", {30'd0, busy, done}, 32'd1);
    @(negedge clk);
    chk(!busy && !done, "done_drop", {30'd0, busy, done}, 32'd0);
  endtask

  task automatic chk_zero(input string nm);
    chk(!busy && !done, {nm, "_ctl"}, {30'd0, busy, done}, 32'd0);
    chk(diff == '0, {nm, "_diff"}, 32'(diff), 32'd0);
    chk(borrow == 1'b0, {nm, "_borrow"}, 32'(borrow), 32'd0);
    chk(overflow == 1'b0, {nm, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    @(negedge clk);
    start = 1'b1;
    a_i   = 16'd5;
    b_i   = 16'd3;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk_zero("reset");
    @(negedge clk);
    chk(!busy, "start_in_reset", 32'(busy), 32'd0);

    do_op(16'd5, 16'd3);
    do_op(16'd3, 16'd5);
    do_op(16'h0000, 16'h0000);
    do_op(16'hFFFF, 16'hFFFF);
    do_op(16'h0000, 16'h0001);
    do_op(16'h8000, 16'h0001);
    do_op(16'h7FFF, 16'hFFFF);
    for (int i = 0; i < 12; i++) begin
      do_op(W'($urandom), W'($urandom));
    end

    // start held high: only every P-th edge may capture operands.
    for (int j = 0; j < 3 * P; j++) begin
      a_i   = W'($urandom);
      b_i   = W'($urandom);
      start = 1'b1;
      if (j % P == 0) exp_q.push_back(model(a_i, b_i));
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk(exp_q.size() == 0, "held_drain", 32'(exp_q.size()), 32'd0);

    // Abort a run with reset at edge k+7.
    a_i   = 16'h1234;
    b_i   = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    reset = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    chk(!busy && !done, "abort_idle", {30'd0, busy, done}, 32'd0);
    do_op(W'($urandom), W'($urandom));
    do_op(16'h8000, 16'h7FFF);

    repeat (4) @(negedge clk);
    chk(exp_q.size() == 0, "final_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
